// File: rtl/insn_encoder_loader_pkg.sv
// rtl/insn_encoder_loader_pkg.sv - shared opcode numbering, word fields and loader states
// Contents: OP_* opcode indices (shared with the instruction-register decoder),
//           instruction word field positions, FSM state constants, encode_word().
package insn_encoder_loader_pkg;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LD   = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_SHR  = 5'd10;
  localparam logic [4:0] OP_JMP  = 5'd11;
  localparam logic [4:0] OP_JZ   = 5'd12;
  localparam logic [4:0] OP_JNZ  = 5'd13;
  localparam logic [4:0] OP_CALL = 5'd14;
  localparam logic [4:0] OP_RET  = 5'd15;
  localparam logic [4:0] OP_PUSH = 5'd16;
  localparam logic [4:0] OP_POP  = 5'd17;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits [10:8] are reserved and always written as zero.
  function automatic logic [15:0] encode_word(input logic [4:0] opc, input logic [7:0] imm_v);
    logic [15:0] w_word;
    w_word = '0;
    w_word[OPC_HI:OPC_LO] = opc;
    w_word[IMM_HI:IMM_LO] = imm_v;
    return w_word;
  endfunction

endpackage

// File: rtl/insn_encoder_loader_if.sv
// rtl/insn_encoder_loader_if.sv - control, operand stream and memory write bus of the loader
// Signals: start/base_addr/len (run setup), op_onehot/imm/in_valid/in_ready (operand stream),
//          mem_busy/mem_we/mem_addr/mem_wdata (program RAM writes),
//          busy/done/err/words_written (status).
// Modports: master = host/loader and RAM side, slave = insn_encoder_loader.
interface insn_encoder_loader_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic [17:0]       op_onehot;
  logic [7:0]        imm;
  logic              in_valid;
  logic              in_ready;
  logic              mem_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [LEN_W-1:0]  words_written;

  modport master (
    output start, base_addr, len, op_onehot, imm, in_valid, mem_busy,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_written
  );

  modport slave (
    input  start, base_addr, len, op_onehot, imm, in_valid, mem_busy,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_written
  );
endinterface

// File: rtl/insn_encoder_loader_onehot18_encoder.sv
// rtl/insn_encoder_loader_onehot18_encoder.sv - 18-bit one-hot to 5-bit index, combinational
// Ports: i_onehot (operation select), o_index (position of the set bit),
//        o_valid (exactly one bit set).
module onehot18_encoder (
  input  logic [17:0] i_onehot,
  output logic [4:0]  o_index,
  output logic        o_valid
);

  logic [4:0] w_count;

  // o_index is only meaningful when o_valid; the caller substitutes nop otherwise.
  always_comb begin
    o_index = '0;
    w_count = '0;
    o_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if (i_onehot[k]) begin
        o_index = 5'(k);
        w_count = w_count + 5'd1;
      end
    end
    o_valid = (w_count == 5'd1);
  end

endmodule

// File: rtl/insn_encoder_loader.sv
// rtl/insn_encoder_loader.sv - encodes (one-hot op, imm) pairs and writes them to program RAM
// Ports: i_clk (clock), i_rst (async active-high reset),
//        bus (insn_encoder_loader_if.slave: run setup, operand stream, RAM writes, status).
module insn_encoder_loader
  import insn_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  insn_encoder_loader_if.slave  bus
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_accepted;
  logic [LEN_W-1:0]  r_words;
  logic              r_mem_we;
  logic [15:0]       r_wdata;
  logic              r_err;

  logic [4:0]        w_idx;
  logic              w_onehot_ok;
  logic [15:0]       w_word;
  logic              w_in_ready;
  logic              w_fire;
  logic              w_complete;
  logic [LEN_W-1:0]  w_words_nxt;

  onehot18_encoder u_enc (
    .i_onehot (bus.op_onehot),
    .o_index  (w_idx),
    .o_valid  (w_onehot_ok)
  );

  assign w_word = encode_word(w_onehot_ok ? w_idx : OP_NOP, bus.imm);

  // A pending write that completes this edge frees the output stage, so a new
  // word can be accepted in the same cycle (1 word/cycle). A stalled write
  // blocks acceptance because mem_busy is high.
  assign w_in_ready  = (r_state == ST_RUN) && !bus.mem_busy && (r_accepted < r_len);
  assign w_fire      = bus.in_valid && w_in_ready;
  assign w_complete  = r_mem_we && !bus.mem_busy;
  assign w_words_nxt = r_words + LEN_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_accepted <= '0;
      r_words    <= '0;
      r_mem_we   <= 1'b0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_addr     <= bus.base_addr;
            r_len      <= bus.len;
            r_accepted <= '0;
            r_words    <= '0;
            r_err      <= 1'b0;
            r_state    <= (bus.len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_fire) begin
            r_mem_we   <= 1'b1;
            r_wdata    <= w_word;
            r_accepted <= r_accepted + LEN_W'(1);
            if (!w_onehot_ok) r_err <= 1'b1;
          end else if (w_complete) begin
            r_mem_we <= 1'b0;
          end
          if (w_complete) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_words <= w_words_nxt;
            // The final completion can never coincide with a fire: every word is already accepted.
            if (w_words_nxt == r_len) r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wdata     = r_wdata;
  assign bus.busy          = (r_state == ST_RUN);
  assign bus.done          = (r_state == ST_DONE);
  assign bus.err           = r_err;
  assign bus.words_written = r_words;

endmodule

// File: tb/tb_insn_encoder_loader.sv
// tb/tb_insn_encoder_loader.sv - self-checking bench for insn_encoder_loader
module tb_insn_encoder_loader;

  logic clk;
  logic rst;

  insn_encoder_loader_if #(.ADDR_W(8), .LEN_W(9)) bus ();

  insn_encoder_loader #(.ADDR_W(8), .LEN_W(9)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] op;
    logic [7:0]  imm;
    logic [7:0]  base;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  vec_t vt[8];
  wr_t  log_q[$];
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   we_cnt;

  // Write monitor: sampled mid-way between the falling edge and the next rising edge,
  // after the stimulus (driven at negedge+1/+2) has settled.
  always @(negedge clk) begin
    #3;
    cyc = cyc + 1;
    if (!rst && bus.mem_we) begin
      we_cnt = we_cnt + 1;
      if (!bus.mem_busy) log_q.push_back('{addr: bus.mem_addr, data: bus.mem_wdata, cyc: cyc});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_in_ready"}, bus.in_ready, 0);
    chk({pfx, "_mem_we"}, bus.mem_we, 0);
    chk({pfx, "_mem_addr"}, bus.mem_addr, 0);
    chk({pfx, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({pfx, "_busy"}, bus.busy, 0);
    chk({pfx, "_done"}, bus.done, 0);
    chk({pfx, "_err"}, bus.err, 0);
    chk({pfx, "_words"}, bus.words_written, 0);
  endtask

  // Ends at negedge+1 of the cycle after start was sampled.
  task automatic start_run(input logic [7:0] base, input logic [8:0] ln);
    @(negedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.len = ln;
    @(negedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Holds in_valid high and returns at negedge+1 after the handshake edge.
  task automatic send_word(input logic [17:0] op, input logic [7:0] im);
    bit ok;
    ok = 1'b0;
    bus.op_onehot = op; bus.imm = im; bus.in_valid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      #1;
      if (bus.in_ready) ok = 1'b1;
      @(negedge clk); #1;
    end
    chk("send_accept", ok, 1);
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (bus.done) seen = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_busy_at_done"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int we_before;
    n_cmp = 0; n_fail = 0; cyc = 0; we_cnt = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.op_onehot = '0; bus.imm = '0; bus.in_valid = 1'b0; bus.mem_busy = 1'b0;

    vt[0] = '{op: 18'h00002, imm: 8'h5A, base: 8'h10, exp_data: 16'h085A, exp_err: 1'b0};
    vt[1] = '{op: 18'h20000, imm: 8'hFF, base: 8'h11, exp_data: 16'h88FF, exp_err: 1'b0};
    vt[2] = '{op: 18'h00006, imm: 8'h12, base: 8'h12, exp_data: 16'h0012, exp_err: 1'b1};
    vt[3] = '{op: 18'h00001, imm: 8'h33, base: 8'h13, exp_data: 16'h0033, exp_err: 1'b0};
    vt[4] = '{op: 18'h00000, imm: 8'h7E, base: 8'h14, exp_data: 16'h007E, exp_err: 1'b1};
    vt[5] = '{op: 18'h00020, imm: 8'hA5, base: 8'h15, exp_data: 16'h28A5, exp_err: 1'b0};
    vt[6] = '{op: 18'h10000, imm: 8'h01, base: 8'h16, exp_data: 16'h8001, exp_err: 1'b0};
    vt[7] = '{op: 18'h3FFFF, imm: 8'hC3, base: 8'h17, exp_data: 16'h00C3, exp_err: 1'b1};

    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Single-word runs over the encoding table.
    for (int i = 0; i < 8; i++) begin
      log_q.delete();
      start_run(vt[i].base, 9'd1);
      chk("vec_busy_after_start", bus.busy, 1);
      chk("vec_err_cleared", bus.err, 0);
      send_word(vt[i].op, vt[i].imm);
      bus.in_valid = 1'b0;
      wait_done("vec");
      chk("vec_err", bus.err, vt[i].exp_err);
      chk("vec_words", bus.words_written, 1);
      chk("vec_nwrites", log_q.size(), 1);
      if (log_q.size() > 0) begin
        chk("vec_addr", log_q[0].addr, vt[i].base);
        chk("vec_data", log_q[0].data, vt[i].exp_data);
      end
      @(negedge clk); #1;
      chk("vec_done_one_cycle", bus.done, 0);
      chk("vec_err_sticky", bus.err, vt[i].exp_err);
    end

    // Back-to-back stream of 4 pops.
    log_q.delete();
    we_before = we_cnt;
    start_run(8'h50, 9'd4);
    for (int j = 0; j < 4; j++) send_word(18'h20000, 8'(j + 1));
    chk("stream_in_ready_full", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    wait_done("stream");
    chk("stream_nwrites", log_q.size(), 4);
    chk("stream_we_cycles", we_cnt - we_before, 4);
    if (log_q.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("stream_addr", log_q[j].addr, 8'h50 + 8'(j));
        chk("stream_data", log_q[j].data, 16'h8800 | 16'(j + 1));
        chk("stream_consecutive", log_q[j].cyc, log_q[0].cyc + j);
      end
    end

    // Address wrap.
    log_q.delete();
    start_run(8'hFE, 9'd3);
    send_word(18'h00002, 8'hA0);
    send_word(18'h00004, 8'hA1);
    send_word(18'h00008, 8'hA2);
    bus.in_valid = 1'b0;
    wait_done("wrap");
    chk("wrap_words", bus.words_written, 3);
    chk("wrap_nwrites", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("wrap_addr0", log_q[0].addr, 8'hFE);
      chk("wrap_addr1", log_q[1].addr, 8'hFF);
      chk("wrap_addr2", log_q[2].addr, 8'h00);
      chk("wrap_data2", log_q[2].data, 16'h18A2);
    end

    // mem_busy stall on the second write.
    log_q.delete();
    start_run(8'h20, 9'd3);
    send_word(18'h00008, 8'h11);
    send_word(18'h00010, 8'h22);
    bus.mem_busy = 1'b1;
    bus.op_onehot = 18'h00100; bus.imm = 8'h33;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("stall_mem_we", bus.mem_we, 1);
      chk("stall_addr", bus.mem_addr, 8'h21);
      chk("stall_data", bus.mem_wdata, 16'h2022);
      chk("stall_in_ready", bus.in_ready, 0);
      @(negedge clk); #1;
    end
    bus.mem_busy = 1'b0;
    send_word(18'h00100, 8'h33);
    bus.in_valid = 1'b0;
    wait_done("stall");
    chk("stall_nwrites", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("stall_w0", {log_q[0].addr, log_q[0].data}, {8'h20, 16'h1811});
      chk("stall_w1", {log_q[1].addr, log_q[1].data}, {8'h21, 16'h2022});
      chk("stall_w2", {log_q[2].addr, log_q[2].data}, {8'h22, 16'h4033});
    end

    // len == 0: done on the next cycle, no write.
    we_before = we_cnt;
    start_run(8'h33, 9'd0);
    chk("len0_done", bus.done, 1);
    chk("len0_busy", bus.busy, 0);
    @(negedge clk); #1;
    chk("len0_done_one_cycle", bus.done, 0);
    chk("len0_no_we", we_cnt - we_before, 0);

    // Reset in the middle of a 5-word run.
    log_q.delete();
    start_run(8'h60, 9'd5);
    send_word(18'h00002, 8'h01);
    send_word(18'h00002, 8'h02);
    send_word(18'h00002, 8'h03);
    bus.in_valid = 1'b0;
    chk("midrst_we_before", bus.mem_we, 1);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    chk("midrst_nwrites", log_q.size(), 2);
    log_q.delete();
    start_run(8'h40, 9'd2);
    send_word(18'h00040, 8'h0A);
    send_word(18'h00080, 8'h0B);
    bus.in_valid = 1'b0;
    wait_done("after_rst");
    chk("after_rst_nwrites", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("after_rst_w0", {log_q[0].addr, log_q[0].data}, {8'h40, 16'h300A});
      chk("after_rst_w1", {log_q[1].addr, log_q[1].data}, {8'h41, 16'h380B});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
